// File: rtl/pcmcia_access_ctrl.sv
// rtl/pcmcia_access_ctrl.sv - PCMCIA host cycle sequencer for SRAM banks, CIS ROM and COR
// Optional host wait generation is enabled by defining PCMCIA_WAIT_EN.
`timescale 1ns/1ps
module pcmcia_access_ctrl #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned PULSE_CYC    = 3,
  parameter int unsigned RECOVERY_CYC = 1,
  parameter logic [6:0]  COR_ADDR     = 7'h00
) (
  input  logic       CLK,
  input  logic       _RST,
  input  logic       _CE1,
  input  logic       _CE2,
  input  logic       _REG,
  input  logic       _OE,
  input  logic       _WE,
  input  logic       A21,
  input  logic [7:0] A,
  input  logic       RAM_SIZE,
  input  logic       WP,
  input  logic [7:0] D_IN,
  output logic       CE_LOW,
  output logic       CE_HIGH,
  output logic       _SRAM_OE,
  output logic       _SRAM_WE,
  output logic       D_OE_LOW,
  output logic       D_OE_HIGH,
  output logic       CIS_RD,
  output logic [7:0] COR,
  output logic       _WAIT
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || PULSE_CYC < 1 || PULSE_CYC > 15 ||
      RECOVERY_CYC < 1 || RECOVERY_CYC > 15) begin : g_bad_param
    $error("pcmcia_access_ctrl: timing parameters must lie in 1..15");
  end

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] RECOV_LD = 4'(RECOVERY_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_EXTEND, S_RECOVER} state_t;

  typedef struct packed {
    logic       attr;
    logic       wr;
    logic       lo;
    logic       hi;
    logic       a21;
    logic       ramsz;
    logic       wp;
    logic [6:0] addr;
  } cyc_t;

  logic [4:0] sync_q1, sync_q2;
  logic       ce1_s, ce2_s, reg_s, oe_s, we_s;
  logic       unused_a0;

  state_t     state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic       armed_q, armed_n;
  cyc_t       cyc_q, cyc_n;
  logic       cor_wr, start, host_rel, idle_strobes;
  logic       active, drive, bank_lo, bank_hi, bank_ok, rd;
  logic       ce_low_d, ce_high_d, sram_oe_d, sram_we_d, d_oe_low_d, d_oe_high_d, cis_rd_d, wait_d;

  assign unused_a0 = A[0];
  assign {reg_s, we_s, oe_s, ce2_s, ce1_s} = sync_q2;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= {_REG, _WE, _OE, _CE2, _CE1};
      sync_q2 <= sync_q1;
    end
  end

  // Armed only re-arms once every strobe is seen released, so one host strobe = one cycle.
  assign idle_strobes = ce1_s && ce2_s && oe_s && we_s;
  assign start        = armed_q && (!ce1_s || !ce2_s) && (oe_s ^ we_s);
  assign host_rel     = (cyc_q.wr ? we_s : oe_s) || (ce1_s && ce2_s);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    armed_n = armed_q;
    cyc_n   = cyc_q;
    cor_wr  = 1'b0;
    if (idle_strobes) armed_n = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n     = S_SETUP;
          cnt_n       = SETUP_LD;
          armed_n     = 1'b0;
          cyc_n.attr  = !reg_s;
          cyc_n.wr    = !we_s;
          cyc_n.lo    = !ce1_s;
          cyc_n.hi    = !ce2_s;
          cyc_n.a21   = A21;
          cyc_n.ramsz = RAM_SIZE;
          cyc_n.wp    = WP;
          cyc_n.addr  = A[7:1];
        end
      end
      S_SETUP: begin
        if (host_rel) begin
          state_n = S_RECOVER;
          cnt_n   = RECOV_LD;
        end else if (cnt_q == 4'd0) begin
          state_n = S_STROBE;
          cnt_n   = PULSE_LD;
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        // An abort wins over completion, so an aborted COR write never commits.
        if (host_rel) begin
          state_n = S_RECOVER;
          cnt_n   = RECOV_LD;
        end else if (cnt_q == 4'd0) begin
          state_n = S_EXTEND;
          cor_wr  = cyc_q.attr && cyc_q.wr && (cyc_q.addr == COR_ADDR);
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      S_EXTEND: begin
        if (host_rel) begin
          state_n = S_RECOVER;
          cnt_n   = RECOV_LD;
        end
      end
      S_RECOVER: begin
        if (cnt_q == 4'd0) state_n = S_IDLE;
        else               cnt_n   = cnt_q - 4'd1;
      end
      default: state_n = S_IDLE;
    endcase

    active      = (state_n != S_IDLE);
    drive       = (state_n == S_STROBE) || (state_n == S_EXTEND);
    rd          = !cyc_n.wr;
    bank_lo     = !cyc_n.attr && !cyc_n.a21;
    bank_hi     = !cyc_n.attr && cyc_n.a21 && !cyc_n.ramsz;
    bank_ok     = bank_lo || bank_hi;
    ce_low_d    = active && bank_lo;
    ce_high_d   = active && bank_hi;
    sram_oe_d   = !(drive && rd && bank_ok);
    sram_we_d   = !((state_n == S_STROBE) && cyc_n.wr && bank_ok && !cyc_n.wp);
    d_oe_low_d  = drive && rd && (cyc_n.attr || (bank_ok && cyc_n.lo));
    d_oe_high_d = drive && rd && bank_ok && cyc_n.hi;
    cis_rd_d    = drive && rd && cyc_n.attr;
  end

`ifdef PCMCIA_WAIT_EN
  assign wait_d = !((state_n == S_SETUP) || (state_n == S_STROBE));
`else
  assign wait_d = 1'b1;
`endif

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      cyc_q     <= '0;
      CE_LOW    <= 1'b0;
      CE_HIGH   <= 1'b0;
      _SRAM_OE  <= 1'b1;
      _SRAM_WE  <= 1'b1;
      D_OE_LOW  <= 1'b0;
      D_OE_HIGH <= 1'b0;
      CIS_RD    <= 1'b0;
      _WAIT     <= 1'b1;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      armed_q   <= armed_n;
      cyc_q     <= cyc_n;
      CE_LOW    <= ce_low_d;
      CE_HIGH   <= ce_high_d;
      _SRAM_OE  <= sram_oe_d;
      _SRAM_WE  <= sram_we_d;
      D_OE_LOW  <= d_oe_low_d;
      D_OE_HIGH <= d_oe_high_d;
      CIS_RD    <= cis_rd_d;
      _WAIT     <= wait_d;
    end
  end

  // Writing SRESET clears the whole register one cycle later.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST)       COR <= 8'h00;
    else if (COR[7]) COR <= 8'h00;
    else if (cor_wr) COR <= D_IN;
  end

endmodule
